instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of fetched-instruction buffer entries (power of two, >=2).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, value driven on instruction_o when no valid instruction is presented.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port imem_req_valid_o, output, 1, fetch request valid.
REQ-007 SHALL have port imem_req_ready_i, input, 1, memory accepts request.
REQ-008 SHALL have port imem_req_addr_o, output, 32, fetch address, word-aligned.
REQ-009 SHALL have port imem_rsp_valid_i, input, 1, response valid; responses arrive in request order, no backpressure.
REQ-010 SHALL have port imem_rsp_data_i, input, 32, fetched instruction word.
REQ-011 SHALL have port redirect_i, input, 1, control-flow redirect pulse from core.
REQ-012 SHALL have port redirect_pc_i, input, 32, redirect target.
REQ-013 SHALL have port stall_i, input, 1, core cannot consume this cycle.
REQ-014 SHALL have port valid_o, output, 1, pc_o/instruction_o hold a valid instruction.
REQ-015 SHALL have port pc_o, output, 32, PC of presented instruction (core pc_i).
REQ-016 SHALL have port instruction_o, output, 32, presented instruction (core instruction_i).

Function
REQ-017 SHALL hold a fetch PC register; a request transfers in a cycle where imem_req_valid_o && imem_req_ready_i, after which fetch PC += 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-018 SHALL assert imem_req_valid_o only when (outstanding + fifo_count) < FIFO_DEPTH and redirect_i is low; imem_req_addr_o SHALL equal fetch PC and stay stable while valid && !ready.
REQ-019 SHALL record the address of each accepted request in an in-order PC queue (depth FIFO_DEPTH) paired with its response.
REQ-020 SHALL, on imem_rsp_valid_i with drop_cnt == 0, push {queued PC, imem_rsp_data_i} into the FIFO in the same edge; minimum request-to-valid_o latency is 2 cycles (response cycle +1).
REQ-021 SHALL present the FIFO head: valid_o = !empty; pc_o/instruction_o = head entry when valid, else pc_o = 0 and instruction_o = NOP_INSTR.
REQ-022 SHALL pop the head when valid_o && !stall_i; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 SHALL, on redirect_i: empty the FIFO, set fetch PC = {redirect_pc_i[31:2], 2'b00}, set drop_cnt = outstanding requests (including one accepted that cycle), clear PC queue; redirect overrides stall_i and any same-cycle pop/push.
REQ-024 SHALL, on imem_rsp_valid_i with drop_cnt > 0, discard the response and decrement drop_cnt; a response in the redirect cycle itself SHALL be discarded.
REQ-025 SHALL never overflow the FIFO (guaranteed by REQ-018 credit rule); a response arriving with no outstanding request is a protocol error and SHALL be ignored.
REQ-026 SHALL take back-to-back redirects, each fully superseding the previous.

Reset
REQ-027 SHALL, while rst is high at a clock edge: fetch PC = RESET_PC, FIFO and PC queue empty, outstanding = 0, drop_cnt = 0, imem_req_valid_o = 0, valid_o = 0, pc_o = 0, instruction_o = NOP_INSTR.
REQ-028 SHALL discard all in-flight requests on reset mid-operation; responses arriving in the cycle after rst deasserts SHALL be ignored (outstanding = 0).
REQ-029 SHALL assert imem_req_valid_o in the first cycle after rst deasserts.

Verification
REQ-030 Reset then ready=1, 1-cycle memory returning 0x00500093, 0x00A00113 -> valid_o with pc_o 0x0, 0x4 on consecutive cycles, first valid 2 cycles after first request.
REQ-031 stall_i held high 5 cycles with full FIFO -> imem_req_valid_o low, pc_o/instruction_o unchanged, no entry lost; release -> PCs continue 0x8, 0xC in order.
REQ-032 redirect_i with redirect_pc_i=0x103 while 2 requests outstanding -> both responses dropped, next request addr 0x100, next valid_o pc_o=0x100.
REQ-033 imem_req_ready_i low 3 cycles -> imem_req_addr_o stable, PC advances only on acceptance.
REQ-034 redirect_pc_i=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-035 rst asserted with full FIFO and outstanding request -> next cycle valid_o=0, instruction_o=0x00000013, request addr RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests under a credit limit,
// pairs in-order responses with their PCs and presents them to the core through a small FIFO.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,

    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,

    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;       // live requests awaiting a response
    logic [31:0]   drop_q, drop_d;         // superseded requests whose responses are discarded

    // In-order queue of accepted request addresses
    logic [31:0]   pcq_q [FIFO_DEPTH];
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;

    // Fetched instruction buffer
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          credit_ok;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_any;
    logic          rsp_drop;
    logic          rsp_live;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [31:0]   inflight_total;
    logic [1:0]    unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // Live in-flight requests plus buffered entries never exceed the buffer size,
    // so every live response always finds a free FIFO slot.
    assign credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
    assign req_valid  = !rst && !redirect_i && credit_ok;
    assign req_fire   = req_valid && imem_req_ready_i;

    assign rsp_any    = imem_rsp_valid_i && ((drop_q != 32'd0) || (outst_q != '0));
    assign rsp_drop   = imem_rsp_valid_i && (drop_q != 32'd0);
    assign rsp_live   = imem_rsp_valid_i && (drop_q == 32'd0) && (outst_q != '0);

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_push  = rsp_live && !redirect_i;
    assign fifo_pop   = !fifo_empty && !stall_i && !redirect_i;

    // Everything still owed by memory after this edge, less any response consumed now
    assign inflight_total = drop_q + 32'(outst_q) + 32'(req_fire) - 32'(rsp_any);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            drop_d     = inflight_total;
            outst_d    = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + AW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - 32'd1;
            end
            if (rsp_live) begin
                pcq_rd_d = pcq_rd_q + AW'(1);
            end
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_live);

            if (fifo_push) begin
                fifo_wr_d = fifo_wr_q + AW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage arrays carry no reset; the pointers and counts above define validity.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (fifo_push && !rst) begin
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
            fifo_data_q[fifo_wr_q] <= imem_rsp_data_i;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;

    assign valid_o       = !fifo_empty;
    assign pc_o          = fifo_empty ? 32'd0     : fifo_pc_q[fifo_rd_q];
    assign instruction_o = fifo_empty ? NOP_INSTR : fifo_data_q[fifo_rd_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, checked every cycle
// against a queue-based model of in-flight requests and buffered instructions.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid_o(imem_req_valid),
    .imem_req_ready_i(imem_req_ready),
    .imem_req_addr_o (imem_req_addr),
    .imem_rsp_valid_i(imem_rsp_valid),
    .imem_rsp_data_i (imem_rsp_data),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .stall_i         (stall),
    .valid_o         (valid),
    .pc_o            (pc),
    .instruction_o   (instruction)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counters
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus knobs
  int rsp_prob  = 100;
  int spur_prob = 0;

  // memory environment: addresses accepted and not yet answered
  logic [31:0] mem_q[$];

  // reference model
  typedef struct {
    logic [31:0] pc;
    bit          dropped;
  } infl_t;
  infl_t       infl_q[$];
  logic [63:0] exp_q[$];   // {pc, instruction} waiting to be presented
  logic [31:0] m_pc;

  // sampled DUT outputs
  logic        s_req_valid;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, compare outputs at negedge, advance model at posedge.
  task automatic step(input bit check);
    int          live;
    bit          e_req_valid;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    infl_t       f;

    if (mem_q.size() > 0 && $urandom_range(0, 99) < rsp_prob) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0]);
    end else if (mem_q.size() == 0 && $urandom_range(0, 99) < spur_prob) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    live = 0;
    foreach (infl_q[i]) if (!infl_q[i].dropped) live++;
    e_req_valid = !rst && !redirect && ((live + exp_q.size()) < DEPTH);
    e_addr      = m_pc;
    e_valid     = exp_q.size() > 0;
    e_pc        = e_valid ? exp_q[0][63:32] : 32'h0;
    e_instr     = e_valid ? exp_q[0][31:0]  : NOP_INSTR;

    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_valid     = valid;
    s_pc        = pc;
    s_instr     = instruction;
    if (check) begin
      chk("req_valid", s_req_valid, e_req_valid);
      chk("req_addr",  s_addr,      e_addr);
      chk("valid",     s_valid,     e_valid);
      chk("pc",        s_pc,        e_pc);
      chk("instr",     s_instr,     e_instr);
    end

    @(posedge clk);
    if (rst) begin
      mem_q.delete();
      infl_q.delete();
      exp_q.delete();
      m_pc = RESET_PC;
    end else begin
      if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (s_req_valid && imem_req_ready) mem_q.push_back(s_addr);

      if (redirect) begin
        if (imem_rsp_valid && infl_q.size() > 0) void'(infl_q.pop_front());
        foreach (infl_q[i]) infl_q[i].dropped = 1'b1;
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (e_valid && !stall) void'(exp_q.pop_front());
        if (imem_rsp_valid && infl_q.size() > 0) begin
          f = infl_q.pop_front();
          if (!f.dropped) exp_q.push_back({f.pc, imem_rsp_data});
        end
        if (e_req_valid && imem_req_ready) begin
          infl_q.push_back('{pc: m_pc, dropped: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] cap_addr;
    bit          got;

    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    m_pc           = RESET_PC;

    // reset
    step(0);
    step(1);
    step(1);
    chk("rst_req_valid", s_req_valid, 1'b0);
    chk("rst_valid",     s_valid,     1'b0);
    chk("rst_pc",        s_pc,        32'h0);
    chk("rst_instr",     s_instr,     NOP_INSTR);

    // first fetches with a one-cycle memory
    rst = 1'b0;
    step(1);
    chk("first_req_valid", s_req_valid, 1'b1);
    chk("first_req_addr",  s_addr,      RESET_PC);
    step(1);
    chk("lat_not_yet", s_valid, 1'b0);
    step(1);
    chk("first_valid", s_valid, 1'b1);
    chk("first_pc",    s_pc,    32'h0);
    chk("first_instr", s_instr, 32'h0050_0093);
    step(1);
    chk("second_pc",    s_pc,    32'h4);
    chk("second_instr", s_instr, 32'h00A0_0113);

    // stall with a full buffer
    stall = 1'b1;
    hold_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 2) hold_pc = s_pc;
      if (i > 2) begin
        chk("stall_req_low", s_req_valid, 1'b0);
        chk("stall_pc_hold", s_pc, hold_pc);
      end
    end
    stall = 1'b0;
    step(1);
    chk("release_pc0", s_pc, hold_pc);
    step(1);
    chk("release_pc1", s_pc, hold_pc + 32'd4);

    // redirect with two requests outstanding
    rsp_prob = 0;
    repeat (4) step(1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step(1);
    chk("redir_req_low", s_req_valid, 1'b0);
    redirect = 1'b0;
    rsp_prob = 100;
    step(1);
    chk("redir_req_valid", s_req_valid, 1'b1);
    chk("redir_req_addr",  s_addr,      32'h0000_0100);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step(1);
      if (s_valid) got = 1'b1;
    end
    chk("redir_found", got,  1'b1);
    chk("redir_pc",    s_pc, 32'h0000_0100);

    // memory not ready
    imem_req_ready = 1'b0;
    step(1);
    cap_addr = s_addr;
    repeat (2) begin
      step(1);
      chk("notready_addr", s_addr, cap_addr);
    end
    imem_req_ready = 1'b1;
    step(1);
    chk("ready_accept_addr", s_addr, cap_addr);
    step(1);
    chk("ready_next_addr", s_addr, cap_addr + 32'd4);

    // address wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_addr1", s_addr, 32'h0000_0000);

    // reset mid-operation, stray response right after release
    stall = 1'b1;
    repeat (3) step(1);
    rsp_prob = 0;
    step(1);
    rst = 1'b1;
    step(1);
    stall = 1'b0;
    step(1);
    chk("midrst_valid", s_valid, 1'b0);
    chk("midrst_instr", s_instr, NOP_INSTR);
    chk("midrst_addr",  s_addr,  RESET_PC);
    rst       = 1'b0;
    rsp_prob  = 100;
    spur_prob = 100;
    step(1);
    chk("postrst_req_valid", s_req_valid, 1'b1);
    chk("postrst_addr",      s_addr,      RESET_PC);
    spur_prob = 0;
    repeat (4) step(1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rsp_prob = $urandom_range(20, 100);
      spur_prob      = 5;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect       = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst      = 1'b0;
    redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
